// File: rtl/game_pkg.sv
// Shared types and default constants for the scene compositor and game-state controller.
package game_pkg;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    DYING   = 2'd1,
    OVER    = 2'd2,
    RESTART = 2'd3
  } game_state_t;

  localparam int unsigned RGB_W                = 12;
  localparam logic [RGB_W-1:0] KEY_RGB_DEFAULT = 12'hF0F;
  localparam int unsigned LAYERS_DEFAULT       = 24;
  localparam int unsigned FLASH_FRAMES_DEFAULT = 30;
  localparam int unsigned SHOTS_DEFAULT        = 4;

endpackage

// File: rtl/scene_compositor_if.sv
// Pixel, game-control and bullet-slot signals of the scene compositor.
interface scene_compositor_if
  import game_pkg::*;
#(
  parameter int unsigned LAYERS = LAYERS_DEFAULT,
  parameter int unsigned SHOTS  = SHOTS_DEFAULT
);
  logic [9:0]              col;
  logic [9:0]              row;
  logic [RGB_W-1:0]        bg_rgb;
  logic [LAYERS-1:0]       layer_hit;
  logic [LAYERS*RGB_W-1:0] layer_rgb;
  logic                    over_hit;
  logic [RGB_W-1:0]        over_rgb;
  logic                    kill;
  logic                    restart_key;
  logic                    shoot_key;
  logic [SHOTS-1:0]        shot_busy;
  logic [RGB_W-1:0]        rgb_out;
  logic                    game_reset;
  logic                    game_over;
  logic [SHOTS-1:0]        shot_fire;

  modport master (
    output col, row, bg_rgb, layer_hit, layer_rgb, over_hit, over_rgb,
           kill, restart_key, shoot_key, shot_busy,
    input  rgb_out, game_reset, game_over, shot_fire
  );

  modport slave (
    input  col, row, bg_rgb, layer_hit, layer_rgb, over_hit, over_rgb,
           kill, restart_key, shoot_key, shot_busy,
    output rgb_out, game_reset, game_over, shot_fire
  );
endinterface

// File: rtl/shot_allocator.sv
// Round-robin bullet-slot allocator: one launch pulse per shoot_key rising edge.
module shot_allocator #(
  parameter int unsigned SHOTS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             shoot_key,
  input  logic [SHOTS-1:0] shot_busy,
  output logic [SHOTS-1:0] shot_fire
);
  localparam int unsigned PTR_W = (SHOTS > 1) ? $clog2(SHOTS) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;

  logic             shoot_q;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SHOTS-1:0] fire_q, fire_d;
  logic [SHOTS-1:0] busy;
  logic [SUM_W-1:0] sum;
  logic [PTR_W-1:0] idx;
  logic             found;
  logic             shoot_edge;

  assign shoot_edge = shoot_key && !shoot_q;
  // A slot launched last cycle may not show busy yet, so treat it as taken.
  assign busy       = shot_busy | fire_q;

  always_comb begin : search
    fire_d   = '0;
    rr_ptr_d = rr_ptr_q;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    if (en && shoot_edge) begin
      for (int unsigned k = 0; k < SHOTS; k++) begin
        sum = {1'b0, rr_ptr_q} + SUM_W'(k);
        if (sum >= SUM_W'(SHOTS)) sum = sum - SUM_W'(SHOTS);
        idx = sum[PTR_W-1:0];
        if (!found && !busy[idx]) begin
          found       = 1'b1;
          fire_d[idx] = 1'b1;
          rr_ptr_d    = (idx == PTR_W'(SHOTS - 1)) ? '0 : idx + PTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shoot_q  <= 1'b0;
      rr_ptr_q <= '0;
      fire_q   <= '0;
    end else begin
      shoot_q  <= shoot_key;
      rr_ptr_q <= rr_ptr_d;
      fire_q   <= fire_d;
    end
  end

  assign shot_fire = fire_q;
endmodule

// File: rtl/scene_compositor.sv
// Two-stage layer compositor with death-flash / game-over / restart control and shot allocation.
module scene_compositor
  import game_pkg::*;
#(
  parameter int unsigned      LAYERS       = LAYERS_DEFAULT,
  parameter logic [RGB_W-1:0] KEY_RGB      = KEY_RGB_DEFAULT,
  parameter int unsigned      FLASH_FRAMES = FLASH_FRAMES_DEFAULT,
  parameter int unsigned      SHOTS        = SHOTS_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  scene_compositor_if.slave bus
);
  localparam logic [1:0] ST_PLAY    = PLAY;
  localparam logic [1:0] ST_DYING   = DYING;
  localparam logic [1:0] ST_OVER    = OVER;
  localparam logic [1:0] ST_RESTART = RESTART;

  logic [1:0]       state_q, state_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             origin_q, restart_q;
  logic [RGB_W-1:0] pix1_q, pix1_d;
  logic             over_hit_q;
  logic [RGB_W-1:0] over_rgb_q;
  logic [RGB_W-1:0] rgb_out_q, rgb_out_d;
  logic             frame_tick, restart_edge;

  // Frame tick fires once on entry to the origin pixel, not for as long as it is held.
  assign frame_tick   = (bus.col == '0) && (bus.row == '0) && !origin_q;
  assign restart_edge = bus.restart_key && !restart_q;

  always_comb begin : fsm_next
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_PLAY: begin
        if (bus.kill) begin
          state_d     = ST_DYING;
          frame_cnt_d = '0;
        end
      end
      ST_DYING: begin
        if (frame_tick) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (frame_cnt_q == 8'(FLASH_FRAMES - 1)) state_d = ST_OVER;
        end
      end
      ST_OVER: begin
        if (restart_edge) state_d = ST_RESTART;
      end
      default: state_d = ST_PLAY;
    endcase
  end

  // Ascending scan so the highest visible layer index wins.
  always_comb begin : layer_mux
    pix1_d = bus.bg_rgb;
    for (int unsigned i = 0; i < LAYERS; i++) begin
      if (bus.layer_hit[i] && (bus.layer_rgb[i*RGB_W +: RGB_W] != KEY_RGB))
        pix1_d = bus.layer_rgb[i*RGB_W +: RGB_W];
    end
  end

  always_comb begin : overlay
    rgb_out_d = pix1_q;
    if ((state_q == ST_OVER) && over_hit_q)
      rgb_out_d = over_rgb_q;
    else if ((state_q == ST_DYING) && frame_cnt_q[2])
      rgb_out_d = ~pix1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PLAY;
      frame_cnt_q <= '0;
      origin_q    <= 1'b0;
      restart_q   <= 1'b0;
      pix1_q      <= '0;
      over_hit_q  <= 1'b0;
      over_rgb_q  <= '0;
      rgb_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      origin_q    <= (bus.col == '0) && (bus.row == '0);
      restart_q   <= bus.restart_key;
      pix1_q      <= pix1_d;
      over_hit_q  <= bus.over_hit;
      over_rgb_q  <= bus.over_rgb;
      rgb_out_q   <= rgb_out_d;
    end
  end

  shot_allocator #(.SHOTS(SHOTS)) u_shot_allocator (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q == ST_PLAY),
    .shoot_key (bus.shoot_key),
    .shot_busy (bus.shot_busy),
    .shot_fire (bus.shot_fire)
  );

  assign bus.rgb_out    = rgb_out_q;
  assign bus.game_reset = rst || (state_q == ST_RESTART);
  assign bus.game_over  = (state_q == ST_DYING) || (state_q == ST_OVER);
endmodule
